// File: rtl/puf_hd_scheduler.sv
// puf_hd_scheduler: sweeps A x B windows of a PUF response bank, streaming per-pair Hamming distances and their total.
module puf_hd_scheduler #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  parameter int CHUNK = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [$clog2(DEPTH)-1:0]                      wr_addr,
  input  logic [WIDTH-1:0]                              wr_data,
  input  logic                                          start,
  input  logic [$clog2(DEPTH)-1:0]                      base_a,
  input  logic [$clog2(DEPTH):0]                        cnt_a,
  input  logic [$clog2(DEPTH)-1:0]                      base_b,
  input  logic [$clog2(DEPTH):0]                        cnt_b,
  output logic                                          busy,
  output logic                                          pair_valid,
  input  logic                                          pair_ready,
  output logic [$clog2(DEPTH)-1:0]                      pair_ia,
  output logic [$clog2(DEPTH)-1:0]                      pair_ib,
  output logic [$clog2(WIDTH+1)-1:0]                    pair_hd,
  output logic                                          done,
  output logic [$clog2(WIDTH+1)+2*$clog2(DEPTH)-1:0]    total_hd,
  output logic [2*$clog2(DEPTH):0]                      pair_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int HW  = $clog2(WIDTH + 1);
  localparam int TW  = HW + 2 * AW;
  localparam int PW  = 2 * AW + 1;
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] ONE = 1;
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, COUNT = 3'd2, EMIT = 3'd3, FIN = 3'd4;
  logic [2:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] xr;
  logic [AW-1:0]    ba, bb, ia_n, ib_n;
  logic [AW:0]      ca, cb, i, j;
  logic [KW-1:0]    k;
  logic             last_j, last;
  function automatic logic [HW-1:0] pc(input logic [CHUNK-1:0] v);
    pc = '0;
    for (int n = 0; n < CHUNK; n++) pc = pc + HW'(v[n]);
  endfunction
  assign ia_n       = ba + i[AW-1:0];
  assign ib_n       = bb + j[AW-1:0];
  assign last_j     = j == cb - ONE;
  assign last       = last_j && i == ca - ONE;
  assign busy       = state == LOAD || state == COUNT || state == EMIT;
  assign pair_valid = state == EMIT;
  assign done       = state == FIN;
  always_ff @(posedge clk)
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pair_ia  <= '0;
      pair_ib  <= '0;
      pair_hd  <= '0;
      total_hd <= '0;
      pair_cnt <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ba       <= base_a;
          ca       <= cnt_a;
          bb       <= base_b;
          cb       <= cnt_b;
          total_hd <= '0;
          pair_cnt <= '0;
          i        <= '0;
          j        <= '0;
          state    <= (cnt_a == '0 || cnt_b == '0) ? FIN : LOAD;
        end
        LOAD: begin
          xr      <= mem[ia_n] ^ mem[ib_n];
          pair_ia <= ia_n;
          pair_ib <= ib_n;
          pair_hd <= '0;
          k       <= '0;
          state   <= COUNT;
        end
        COUNT: begin
          pair_hd <= pair_hd + pc(xr[k*CHUNK +: CHUNK]);
          k       <= k + KW'(1);
          state   <= (k == KW'(NCH - 1)) ? EMIT : COUNT;
        end
        EMIT: if (pair_ready) begin
          total_hd <= total_hd + TW'(pair_hd);
          pair_cnt <= pair_cnt + PW'(1);
          j        <= last_j ? '0 : j + ONE;
          i        <= last_j ? i + ONE : i;
          state    <= last ? FIN : LOAD;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_hd_scheduler.sv
// tb_puf_hd_scheduler: directed sweeps checked against a pair-list model of the response bank.
module tb_puf_hd_scheduler;
  localparam int W = 128, D = 16, AW = 4, HW = 8;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, pair_ready = 1;
  logic [AW-1:0] wr_addr = 0, base_a = 0, base_b = 0;
  logic [AW:0] cnt_a = 0, cnt_b = 0;
  logic [W-1:0] wr_data = 0;
  logic busy, pair_valid, done;
  logic [AW-1:0] pair_ia, pair_ib;
  logic [HW-1:0] pair_hd;
  logic [HW+2*AW-1:0] total_hd;
  logic [2*AW:0] pair_cnt;
  puf_hd_scheduler dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .base_a(base_a), .cnt_a(cnt_a), .base_b(base_b), .cnt_b(cnt_b),
    .busy(busy), .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_ia(pair_ia),
    .pair_ib(pair_ib), .pair_hd(pair_hd), .done(done), .total_hd(total_hd), .pair_cnt(pair_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {int ia; int ib; int hd;} pair_t;
  int tests = 0, fails = 0;
  logic [W-1:0] bank [D];
  pair_t q[$];
  int ia_log[$];
  int acc_m = 0, cnt_m = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Expected pairs are consumed in order on each accepted handshake.
  always @(negedge clk) if (!rst) begin
    if (busy) begin
      chk("running_total_hd", total_hd, acc_m);
      chk("running_pair_cnt", pair_cnt, cnt_m);
    end
    if (pair_valid) begin
      if (q.size() == 0) chk("pair_valid_unexpected", pair_valid, 0);
      else begin
        chk("pair_ia", pair_ia, q[0].ia);
        chk("pair_ib", pair_ib, q[0].ib);
        chk("pair_hd", pair_hd, q[0].hd);
        if (pair_ready) begin
          acc_m += q[0].hd;
          cnt_m++;
          ia_log.push_back(int'(pair_ia));
          void'(q.pop_front());
        end
      end
    end
    if (done) begin
      chk("done_total_hd", total_hd, acc_m);
      chk("done_pair_cnt", pair_cnt, cnt_m);
      chk("done_pairs_left", q.size(), 0);
    end
  end
  task automatic wr(input int a, input logic [W-1:0] d);
    @(posedge clk); #1;
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 0;
    bank[a] = d;
  endtask
  task automatic sweep(input int ba, input int ca, input int bb, input int cb, input int stall, output int n);
    bit got = 0;
    q.delete(); ia_log.delete(); acc_m = 0; cnt_m = 0;
    for (int a = 0; a < ca; a++)
      for (int b = 0; b < cb; b++)
        q.push_back('{(ba + a) % D, (bb + b) % D, $countones(bank[(ba + a) % D] ^ bank[(bb + b) % D])});
    @(posedge clk); #1;
    base_a = AW'(ba); cnt_a = (AW+1)'(ca); base_b = AW'(bb); cnt_b = (AW+1)'(cb); start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    for (int c = 0; c < 6000 && !got; c++) begin
      n++;
      if (pair_valid && stall > 0) begin pair_ready = 0; stall--; end
      else pair_ready = 1;
      if (done) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk("done_timeout", got, 1);
    pair_ready = 1;
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pair_valid"}, pair_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pair_hd"}, pair_hd, 0);
    chk({tag, "_pair_ia"}, pair_ia, 0);
    chk({tag, "_pair_ib"}, pair_ib, 0);
    chk({tag, "_total_hd"}, total_hd, 0);
    chk({tag, "_pair_cnt"}, pair_cnt, 0);
  endtask
  initial begin
    int n;
    logic [31:0] w;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    chk_reset("reset");
    for (int k = 0; k < D; k++) begin
      w = 32'h9E3779B9 * (k + 1);
      wr(k, {w, ~w, w ^ 32'h5A5A5A5A, w + 32'd7});
    end
    wr(0, 128'h8ACD264CD7AE265E4CBC3A55DAADA974);
    wr(1, 128'h8A6D264CD7AE265E4CBC3A55DAADA974);
    wr(2, '0);
    wr(3, '1);
    sweep(0, 1, 1, 1, 0, n);
    chk("single_latency", n - 1, 6);
    chk("single_total_hd", total_hd, 2);
    chk("single_pair_cnt", pair_cnt, 1);
    sweep(2, 2, 2, 2, 0, n);
    chk("extremes_total_hd", total_hd, 256);
    chk("extremes_pair_cnt", pair_cnt, 4);
    sweep(0, 2, 2, 2, 5, n);
    chk("stall_total_hd", total_hd, 256);
    chk("stall_latency", n - 1, 29);
    sweep(15, 2, 0, 1, 0, n);
    chk("wrap_log_size", ia_log.size(), 2);
    chk("wrap_ia0", ia_log[0], 15);
    chk("wrap_ia1", ia_log[1], 0);
    sweep(4, 3, 0, 0, 0, n);
    chk("empty_done_delay", n, 1);
    chk("empty_total_hd", total_hd, 0);
    chk("empty_pair_cnt", pair_cnt, 0);
    q.delete(); acc_m = 0; cnt_m = 0;
    @(posedge clk); #1;
    base_a = 3; cnt_a = 16; base_b = 0; cnt_b = 16; start = 1;
    @(posedge clk); #1;
    start = 0; wr_en = 1; wr_addr = 7; wr_data = ~bank[7];
    @(posedge clk); #1;
    wr_en = 0;
    chk("busy_in_count", busy, 1);
    chk("pair_ia_in_count", pair_ia, 3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_reset("midreset");
    wr(5, 128'hDEADBEEF0123456789ABCDEFFEEDFACE);
    sweep(0, 16, 0, 16, 0, n);
    chk("full_pair_cnt", pair_cnt, 256);
    chk("full_total_hd", total_hd, acc_m);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/puf_hd_scheduler.md
Name: puf_hd_scheduler

Overview:
Hardware sequencer for on-chip PUF uniqueness and reliability analysis. It holds a small bank of 128-bit PUF response words and, on command, walks every (A,B) pair across two configurable windows of that bank. For each pair it computes the Hamming distance with a shared, chunked popcount datapath, streams the per-pair results out, and reports the accumulated total so host logic can form intra-board and inter-board averages.

Parameters:
WIDTH, 128, bits per response word; must be a multiple of CHUNK
DEPTH, 16, number of response entries; power of two; AW = clog2(DEPTH)
CHUNK, 32, bits popcounted per cycle; NCH = WIDTH/CHUNK

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write response entry
wr_addr  in  AW  entry index
wr_data  in  WIDTH  response word
start  in  1  one-cycle pulse; begins a sweep
base_a  in  AW  first entry of window A
cnt_a  in  AW+1  entries in window A (0..DEPTH)
base_b  in  AW  first entry of window B
cnt_b  in  AW+1  entries in window B (0..DEPTH)
busy  out  1  sweep in progress
pair_valid  out  1  per-pair result valid
pair_ready  in  1  consumer accepts result
pair_ia  out  AW  entry index of A operand
pair_ib  out  AW  entry index of B operand
pair_hd  out  clog2(WIDTH+1)  differing bits in the pair (0..WIDTH)
done  out  1  one-cycle pulse at sweep end
total_hd  out  clog2(WIDTH+1)+2*AW  sum of all pair_hd values in the sweep
pair_cnt  out  2*AW+1  pairs evaluated in the sweep

Behaviour:
- Reset: busy=0, pair_valid=0, done=0, pair_hd=0, pair_ia=0, pair_ib=0, total_hd=0, pair_cnt=0. FSM returns to IDLE. Bank contents are not cleared.
- Reset asserted mid-sweep aborts the sweep. No done pulse is generated.
- Writes: accepted only when busy=0. wr_en while busy=1 is dropped.
- States: IDLE, LOAD, COUNT, EMIT, FIN.
- IDLE, start=1: latch base_a, cnt_a, base_b, cnt_b; clear total_hd and pair_cnt; set i=j=0; set busy=1.
  - If cnt_a==0 or cnt_b==0, go to FIN.
  - Otherwise go to LOAD.
- start while busy=1 is ignored.
- LOAD (1 cycle): read entry (base_a+i) mod DEPTH and entry (base_b+j) mod DEPTH. Register their XOR. Clear the chunk accumulator.
- COUNT (NCH cycles): each cycle add popcount of one CHUNK slice of the XOR to the accumulator, LSB slice first.
- EMIT: pair_valid=1 with stable pair_ia, pair_ib, pair_hd until pair_ready=1.
  - On the handshake cycle: total_hd += pair_hd; pair_cnt += 1.
  - Advance j. When j reaches cnt_b-1, set j=0 and i+=1.
  - When the last pair (i=cnt_a-1, j=cnt_b-1) is accepted, go to FIN; otherwise go to LOAD.
- Minimum latency is 1+NCH+1 cycles per pair, i.e. 6 with the defaults.
- FIN (1 cycle): done=1, busy=0, then IDLE. total_hd and pair_cnt hold until the next start.
- Windows wrap modulo DEPTH and may overlap. Self-pairs (same index) are evaluated and yield 0.
- Accumulator widths are sized so that DEPTH*DEPTH*WIDTH never overflows. No saturation is needed.

Test Plan:
- Load entry0 = 8ACD264CD7AE265E4CBC3A55DAADA974 and entry1 = 8A6D264CD7AE265E4CBC3A55DAADA974. Sweep base_a=0, cnt_a=1, base_b=1, cnt_b=1 -> one pair with pair_hd=2, total_hd=2, pair_cnt=1. done is seen exactly 6 cycles after the first LOAD with pair_ready held at 1.
- Load entry2 = all-zero and entry3 = all-ones. Sweep base_a=2, cnt_a=2, base_b=2, cnt_b=2 -> pairs (2,2)=0, (2,3)=128, (3,2)=128, (3,3)=0, in that order; total_hd=256, pair_cnt=4.
- Backpressure: drop pair_ready for 5 cycles during EMIT -> pair_valid stays high with values stable, no accumulation occurs, and the sweep resumes on the next ready.
- Wrap: base_a=15, cnt_a=2 -> pair_ia sequence is 15 then 0.
- cnt_b=0 -> done pulses 1 cycle after start, pair_valid never asserts, total_hd=0.
- Reset mid-COUNT -> all outputs return to their reset values. Then wr_en to entry 5 is accepted, and a subsequent full 16x16 sweep gives pair_cnt=256.
